// File: rtl/memctrl_pkg.sv
// Shared definitions for the scratch-memory burst controller: default
// geometry of the 64x32 memory and the controller state encoding.
package memctrl_pkg;

    // Default geometry of the attached scratch memory and command fields.
    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_DEPTH_DEF = 64;
    localparam int LEN_W_DEF     = 7;

    // Controller states, kept as plain constants so older tools and
    // netlists see a fixed two-bit encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t WRITE = 2'd1;
    localparam state_t READ  = 2'd2;

endpackage

// File: rtl/mem_rd_stage.sv
// One-entry valid/ready output register for the read path. The owner asks
// for a load only when can_load is high; the entry holds while the consumer
// stalls and drops when consumed or explicitly cleared.
module mem_rd_stage
    import memctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              can_load
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;

    // The slot can take a new word when empty or when its word leaves now.
    assign can_load  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Load has priority over draining so a consumed word is replaced in the
    // same cycle; data is left untouched when the slot empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller for the single-port 64x32 scratch memory.
// Accepts a burst command in IDLE, streams write beats straight onto the
// memory port (commit happens on the memory's falling edge) and streams read
// words out through a one-entry registered stage.
// Build option: define MEMCTRL_WRAP_EN to let bursts wrap from MEM_DEPTH-1
// to address 0 instead of rejecting them.
module mem_burst_ctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Depth expressed one bit wider than an address so that base+length
    // never overflows during the range check.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  remaining_reg, remaining_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              cmd_fire;
    logic              len_too_big;
    logic              range_err;
    logic [ADDR_W-1:0] addr_inc;

    logic              rd_load;
    logic              rd_clear;
    logic              rd_can_load;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign len_too_big = 32'(cmd_len) > 32'(MEM_DEPTH);

`ifdef MEMCTRL_WRAP_EN
    logic addr_oob;

    // With wrapping, only a base outside the memory or an over-long burst
    // is illegal; crossing the top simply continues at address 0.
    assign addr_oob  = {1'b0, cmd_addr} >= DEPTH_EXT;
    assign range_err = len_too_big || addr_oob;
    assign addr_inc  = (addr_reg == ADDR_W'(MEM_DEPTH - 1)) ? '0
                                                            : addr_reg + ADDR_W'(1);
`else
    logic [ADDR_W:0] span_end;

    // Without wrapping, the whole burst must fit below MEM_DEPTH.
    assign span_end  = {1'b0, cmd_addr} + (ADDR_W+1)'(cmd_len);
    assign range_err = len_too_big || (span_end > DEPTH_EXT);
    assign addr_inc  = addr_reg + ADDR_W'(1);
`endif

    // Next-state logic: command decode in IDLE, beat counting in WRITE,
    // fetch scheduling and completion detection in READ.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        rd_load        = 1'b0;
        rd_clear       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    addr_next      = cmd_addr;
                    remaining_next = cmd_len;
                    if (cmd_len == '0) begin
                        done_next = 1'b1;
                    end else if (range_err) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = cmd_write ? WRITE : READ;
                    end
                end
            end

            WRITE: begin
                // Each accepted beat was written this cycle at addr_reg.
                if (wr_valid) begin
                    addr_next      = addr_inc;
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            READ: begin
                // remaining_reg counts words still to fetch; once it is zero
                // the word in the output stage is the last one outstanding.
                if (remaining_reg != '0) begin
                    if (rd_can_load) begin
                        rd_load        = 1'b1;
                        addr_next      = addr_inc;
                        remaining_next = remaining_reg - LEN_W'(1);
                    end
                end else if (rd_valid && rd_ready) begin
                    rd_clear   = 1'b1;
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller state; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    mem_rd_stage #(
        .DATA_W (DATA_W)
    ) u_rd_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_load),
        .clear     (rd_clear),
        .load_data (mem_rdata),
        .out_ready (rd_ready),
        .out_valid (rd_valid),
        .out_data  (rd_data),
        .can_load  (rd_can_load)
    );

    // Memory port is driven combinationally so a write beat commits on the
    // falling edge of the cycle it is presented; reset blocks any write.
    assign cmd_ready = (state_reg == IDLE);
    assign wr_ready  = (state_reg == WRITE);
    assign mem_we    = (state_reg == WRITE) && wr_valid && !rst;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wr_data;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a behavioural scratch memory
// and a word-level reference image of its contents.
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [6:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:63];
    logic [31:0] ref_mem [0:63];
    logic        tb_clear = 1'b1;

    always #5 clk = ~clk;

    mem_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Scratch memory: combinational read, write on the falling edge.
    always @(negedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
        end else if (mem_we && mem_addr < 8'd64) begin
            mem_arr[mem_addr[5:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_addr < 8'd64) ? mem_arr[mem_addr[5:0]] : 32'hDEAD_BEEF;

    // 0 = empty burst (done only), 1 = rejected (err), 2 = real burst.
    function automatic int kind_of(input int a, input int l);
        if (l == 0) return 0;
`ifdef MEMCTRL_WRAP_EN
        if (l > 64 || a >= 64) return 1;
`else
        if (l > 64 || a + l > 64) return 1;
`endif
        return 2;
    endfunction

    // Memory index of the i-th word of a burst starting at a.
    function automatic int ea(input int a, input int i);
`ifdef MEMCTRL_WRAP_EN
        return (a + i) % 64;
`else
        return a + i;
`endif
    endfunction

    task automatic issue(input bit wr, input int addr, input int len);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 8'(addr); cmd_len = 7'(len);
        @(negedge clk);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input int addr, input int len, input int vmode,
                             input logic [31:0] base, input bit seq);
        int beats = 0, last = -10;
        bit finished = 0, exp_done;
        logic [7:0] exp_a;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            wr_valid = (vmode == 0 && beats < len) ? 1'b1 : 1'(($urandom % 2));
            wr_data  = seq ? base + 32'(beats) : $urandom;
            @(negedge clk);
            exp_done = (beats == len) && (cyc == last + 1);
            checks++;
            if (done !== exp_done) begin
                errors++; $display("FAIL wr_done: cyc=%0d done=%b required %b", cyc, done, exp_done);
            end
            checks++;
            if (cmd_ready !== exp_done || wr_ready !== !exp_done) begin
                errors++; $display("FAIL wr_ready_flags: cmd_ready=%b wr_ready=%b required %b/%b",
                                   cmd_ready, wr_ready, exp_done, !exp_done);
            end
            checks++;
            if (mem_we !== (wr_valid && !exp_done)) begin
                errors++; $display("FAIL wr_mem_we: mem_we=%b required %b", mem_we, wr_valid && !exp_done);
            end
            if (exp_done) begin
                finished = 1;
            end else begin
                exp_a = 8'(ea(addr, beats));
                checks++;
                if (mem_addr !== exp_a || (wr_valid && mem_wdata !== wr_data)) begin
                    errors++; $display("FAIL wr_port: addr=%0d data=%h required addr=%0d data=%h",
                                       mem_addr, mem_wdata, exp_a, wr_data);
                end
                if (wr_valid && beats < len) begin
                    ref_mem[ea(addr, beats)] = wr_data;
                    beats++;
                    last = cyc;
                end
                @(posedge clk); #1;
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (!finished) begin
            errors++; $display("FAIL wr_timeout: beats=%0d of %0d, done never seen", beats, len);
        end
        for (int i = 0; i < len; i++) begin
            checks++;
            if (mem_arr[ea(addr, i)] !== ref_mem[ea(addr, i)]) begin
                errors++; $display("FAIL wr_mem_content: word %0d = %h required %h",
                                   ea(addr, i), mem_arr[ea(addr, i)], ref_mem[ea(addr, i)]);
            end
        end
    endtask

    task automatic run_read(input int addr, input int len, input int rmode);
        int hs = 0, last = -10, loaded;
        bit finished = 0, exp_done, prev_stall = 0;
        logic [31:0] prev_data = '0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 3 == 0);
                default: rd_ready = 1'(($urandom % 2));
            endcase
            @(negedge clk);
            exp_done = (hs == len) && (cyc == last + 1);
            checks++;
            if (done !== exp_done || cmd_ready !== exp_done) begin
                errors++; $display("FAIL rd_done: cyc=%0d done=%b cmd_ready=%b required %b",
                                   cyc, done, cmd_ready, exp_done);
            end
            checks++;
            if (mem_we !== 1'b0 || wr_ready !== 1'b0) begin
                errors++; $display("FAIL rd_no_write: mem_we=%b wr_ready=%b required 0/0", mem_we, wr_ready);
            end
            if (cyc == 0 || cyc == 1) begin
                checks++;
                if (rd_valid !== (cyc == 1)) begin
                    errors++; $display("FAIL rd_latency: cyc=%0d rd_valid=%b required %b", cyc, rd_valid, cyc == 1);
                end
            end
            if (exp_done) begin
                finished = 1;
                checks++;
                if (rd_valid !== 1'b0) begin
                    errors++; $display("FAIL rd_end_valid: rd_valid=%b required 0", rd_valid);
                end
            end else begin
                if (rmode == 0 && cyc >= 1 && hs < len) begin
                    checks++;
                    if (rd_valid !== 1'b1) begin
                        errors++; $display("FAIL rd_throughput: cyc=%0d rd_valid=%b required 1", cyc, rd_valid);
                    end
                end
                if (rd_valid === 1'b1) begin
                    checks++;
                    if (hs >= len) begin
                        errors++; $display("FAIL rd_extra_word: rd_valid=1 after %0d words, required 0", hs);
                    end else if (rd_data !== ref_mem[ea(addr, hs)] || (prev_stall && rd_data !== prev_data)) begin
                        errors++; $display("FAIL rd_data: word %0d = %h required %h",
                                           hs, rd_data, ref_mem[ea(addr, hs)]);
                    end
                end
                loaded = hs + (rd_valid ? 1 : 0);
                if (loaded < len) begin
                    checks++;
                    if (mem_addr !== 8'(ea(addr, loaded))) begin
                        errors++; $display("FAIL rd_mem_addr: %0d required %0d", mem_addr, ea(addr, loaded));
                    end
                end
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
                if (rd_valid && rd_ready) begin
                    hs++;
                    last = cyc;
                end
                @(posedge clk); #1;
            end
        end
        rd_ready = 1'b0;
        checks++;
        if (!finished || hs != len) begin
            errors++; $display("FAIL rd_handshakes: %0d handshakes, done=%b, required %0d", hs, finished, len);
        end
    endtask

    task automatic run_noaccess(input int kind);
        for (int cyc = 0; cyc < 3; cyc++) begin
            wr_valid = 1'(($urandom % 2));
            rd_ready = 1'(($urandom % 2));
            @(negedge clk);
            checks++;
            if (done !== (kind == 0 && cyc == 0) || err !== (kind == 1 && cyc == 0)) begin
                errors++; $display("FAIL noaccess_pulse: cyc=%0d done=%b err=%b required %b/%b",
                                   cyc, done, err, kind == 0 && cyc == 0, kind == 1 && cyc == 0);
            end
            checks++;
            if (mem_we !== 1'b0 || cmd_ready !== 1'b1 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
                errors++; $display("FAIL noaccess_idle: mem_we=%b cmd_ready=%b rd_valid=%b wr_ready=%b required 0/1/0/0",
                                   mem_we, cmd_ready, rd_valid, wr_ready);
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic do_burst(input bit wr, input int addr, input int len, input int mode,
                            input logic [31:0] base, input bit seq);
        int k;
        k = kind_of(addr, len);
        $display("cmd wr=%0d addr=%0d len=%0d mode=%0d expect=%s", wr, addr, len, mode,
                 k == 0 ? "empty" : (k == 1 ? "reject" : "burst"));
        issue(wr, addr, len);
        if (k != 2) run_noaccess(k);
        else if (wr) run_write(addr, len, mode, base, seq);
        else run_read(addr, len, mode);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL single_pulse: done=%b err=%b required 0/0", done, err);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 ||
            done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h0) begin
            errors++; $display("FAIL reset_state: cmd_ready=%b wr_ready=%b rd_valid=%b rd_data=%h done=%b err=%b mem_we=%b mem_addr=%0d required 1/0/0/0/0/0/0/0",
                               cmd_ready, wr_ready, rd_valid, rd_data, done, err, mem_we, mem_addr);
        end
        tb_clear = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_release: cmd_ready=%b done=%b err=%b required 1/0/0", cmd_ready, done, err);
        end
    endtask

    task automatic test_basic_burst;
        do_burst(1, 4, 3, 0, 32'hA, 1);
        do_burst(0, 4, 3, 0, 0, 0);
    endtask

    task automatic test_read_stall;
        do_burst(1, 20, 4, 1, 0, 0);
        do_burst(0, 20, 4, 1, 0, 0);
    endtask

    task automatic test_boundaries;
        do_burst(1, 62, 4, 0, 32'h600, 1);
        do_burst(0, 62, 4, 2, 0, 0);
        do_burst(1, 60, 4, 0, 32'h700, 1);
        do_burst(0, 0, 64, 0, 0, 0);
        do_burst(1, 9, 0, 0, 0, 0);
        do_burst(0, 0, 65, 0, 0, 0);
        do_burst(1, 64, 1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_write;
        $display("cmd wr=1 addr=10 len=5 interrupted by reset after 2 beats");
        issue(1, 10, 5);
        for (int b = 0; b < 2; b++) begin
            wr_valid = 1'b1;
            wr_data  = $urandom;
            @(negedge clk);
            ref_mem[10 + b] = wr_data;
            @(posedge clk); #1;
        end
        wr_valid = 1'b1;
        wr_data  = $urandom;
        #1;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++; $display("FAIL pre_reset_we: mem_we=%b required 1", mem_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || cmd_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_write: mem_we=%b cmd_ready=%b wr_ready=%b rd_valid=%b done=%b required 0/1/0/0/0",
                               mem_we, cmd_ready, wr_ready, rd_valid, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wr_valid = 1'b0;
        do_burst(0, 10, 5, 0, 0, 0);
        do_burst(1, 30, 3, 1, 0, 0);
        do_burst(0, 30, 3, 2, 0, 0);
    endtask

    task automatic test_random;
        int a, l;
        for (int n = 0; n < 24; n++) begin
            a = $urandom_range(0, 66);
            l = ($urandom % 5 == 0) ? $urandom_range(60, 127) : $urandom_range(0, 9);
            do_burst(1'(($urandom % 2)), a, l, $urandom_range(0, 2), 0, 0);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 4; n++) begin
            do_burst(1, 8 * n, 8, 0, 32'h100 * n, 1);
            do_burst(0, 8 * n, 8, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset;
        test_basic_burst;
        test_read_stall;
        test_boundaries;
        test_reset_mid_write;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
